// File: rtl/mem_instru.sv
// Instruction memory with a byte-serial program loader; reads are combinational in RUN.
// Build option MEM_INSTRU_CHECKSUM_EN adds load_sum (mod-256 sum of bytes accepted in a session).
module mem_instru #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       direinstru,
  output logic [31:0]       instru,
  input  logic              load_en,
  input  logic [7:0]        load_byte,
  input  logic              load_valid,
  output logic              load_ready,
  output logic              load_done,
  output logic              run,
  output logic [ADDR_W:0]   prog_len,
`ifdef MEM_INSTRU_CHECKSUM_EN
  output logic [7:0]        load_sum,
`endif
  output logic [1:0]        dbg_state
);
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_LOAD = 2'd1, S_RUN = 2'd2} state_t;

  state_t          state_q, state_d;
  logic [ADDR_W:0] wptr_q, wptr_d;
  logic [1:0]      byte_cnt_q, byte_cnt_d;
  logic [23:0]     shift_q, shift_d;
  logic [ADDR_W:0] prog_len_q, prog_len_d;
  logic            load_done_q, load_done_d;
  logic            load_en_q;
  logic            mem_we;
  logic            accept;
  logic            en_rise;
  logic [31:0]     mem [DEPTH];
`ifdef MEM_INSTRU_CHECKSUM_EN
  logic [7:0]      sum_q, sum_d;
`endif

  // Handshake: a byte transfers on every cycle where load_valid and load_ready are both high;
  // load_ready is high for the whole LOAD state, including a cycle where load_en falls.
  assign load_ready = (state_q == S_LOAD);
  assign accept     = load_ready & load_valid;
  assign en_rise    = load_en & ~load_en_q;

  always_comb begin
    state_d     = state_q;
    wptr_d      = wptr_q;
    byte_cnt_d  = byte_cnt_q;
    shift_d     = shift_q;
    prog_len_d  = prog_len_q;
    load_done_d = 1'b0;
    mem_we      = 1'b0;
`ifdef MEM_INSTRU_CHECKSUM_EN
    sum_d       = sum_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (load_en) begin
          state_d    = S_LOAD;
          wptr_d     = '0;
          byte_cnt_d = '0;
`ifdef MEM_INSTRU_CHECKSUM_EN
          sum_d      = '0;
`endif
        end else begin
          state_d = S_RUN;
        end
      end
      S_LOAD: begin
        if (accept) begin
          shift_d    = {shift_q[15:0], load_byte};
          byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef MEM_INSTRU_CHECKSUM_EN
          sum_d      = sum_q + load_byte;
`endif
          if (byte_cnt_q == 2'd3) begin
            mem_we = 1'b1;
            wptr_d = wptr_q + 1'b1;
          end
        end
        // A word completed in the exit cycle is already in wptr_d and gets counted.
        if (!load_en || (wptr_d == (ADDR_W+1)'(DEPTH))) begin
          state_d     = S_RUN;
          prog_len_d  = wptr_d;
          load_done_d = 1'b1;
          byte_cnt_d  = '0;
        end
      end
      S_RUN: begin
        if (en_rise) begin
          state_d    = S_LOAD;
          wptr_d     = '0;
          byte_cnt_d = '0;
`ifdef MEM_INSTRU_CHECKSUM_EN
          sum_d      = '0;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      wptr_q      <= '0;
      byte_cnt_q  <= '0;
      shift_q     <= '0;
      prog_len_q  <= '0;
      load_done_q <= 1'b0;
      load_en_q   <= 1'b0;
`ifdef MEM_INSTRU_CHECKSUM_EN
      sum_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      byte_cnt_q  <= byte_cnt_d;
      shift_q     <= shift_d;
      prog_len_q  <= prog_len_d;
      load_done_q <= load_done_d;
      load_en_q   <= load_en;
`ifdef MEM_INSTRU_CHECKSUM_EN
      sum_q       <= sum_d;
`endif
    end
  end

  // Contents survive reset; a write coinciding with reset is dropped with the session.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) mem[wptr_q[ADDR_W-1:0]] <= {shift_q, load_byte};
  end

  // run falls in the very cycle load_en rises so the core never sees a reloading memory.
  assign run = (state_q == S_RUN) && !en_rise;

  always_comb begin
    instru = '0;
    if (run && (direinstru < 32'(DEPTH))) instru = mem[direinstru[ADDR_W-1:0]];
  end

  assign load_done = load_done_q;
  assign prog_len  = prog_len_q;
  assign dbg_state = state_q;
`ifdef MEM_INSTRU_CHECKSUM_EN
  assign load_sum  = sum_q;
`endif
endmodule

// File: tb/tb_mem_instru.sv
// Bench for mem_instru: directed program loads plus random sessions against a byte-stream model.
module tb_mem_instru;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 256;

  logic              clk;
  logic              reset;
  logic [31:0]       direinstru;
  logic [31:0]       instru;
  logic              load_en;
  logic [7:0]        load_byte;
  logic              load_valid;
  logic              load_ready;
  logic              load_done;
  logic              run;
  logic [ADDR_W:0]   prog_len;
  logic [1:0]        dbg_state;
`ifdef MEM_INSTRU_CHECKSUM_EN
  logic [7:0]        load_sum;
`endif

  mem_instru #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .direinstru (direinstru),
    .instru     (instru),
    .load_en    (load_en),
    .load_byte  (load_byte),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_done  (load_done),
    .run        (run),
    .prog_len   (prog_len),
`ifdef MEM_INSTRU_CHECKSUM_EN
    .load_sum   (load_sum),
`endif
    .dbg_state  (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard / reference model
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] model_mem [DEPTH];
  bit          known [DEPTH];
  logic [7:0]  sess_q [$];
  logic [31:0] exp_q [$];
  int          exp_prog_len;
  logic [7:0]  exp_sum;
  bit          in_load;
  bit          exp_run;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Complete words of the session land big-endian from address 0, capped at DEPTH.
  task automatic commit_words();
    int nw;
    exp_q.delete();
    nw = sess_q.size() / 4;
    if (nw > DEPTH) nw = DEPTH;
    for (int i = 0; i < nw; i++)
      exp_q.push_back({sess_q[4*i], sess_q[4*i+1], sess_q[4*i+2], sess_q[4*i+3]});
    for (int i = 0; i < exp_q.size(); i++) begin
      model_mem[i] = exp_q[i];
      known[i]     = 1'b1;
    end
    exp_sum = 8'h00;
    foreach (sess_q[i]) exp_sum = exp_sum + sess_q[i];
  endtask

  task automatic close_checks();
    commit_words();
    exp_prog_len = exp_q.size();
    in_load      = 1'b0;
    exp_run      = 1'b1;
    check("load_done_pulse", 32'(load_done), 32'd1);
    check("run_after_load", 32'(run), 32'd1);
    check("prog_len", 32'(prog_len), 32'(exp_prog_len));
    check("state_run", 32'(dbg_state), 32'd2);
`ifdef MEM_INSTRU_CHECKSUM_EN
    check("load_sum", 32'(load_sum), 32'(exp_sum));
`endif
  endtask

  // Driver tasks
  task automatic do_reset();
    reset      = 1'b1;
    load_en    = 1'b0;
    load_valid = 1'b0;
    tick();
    if (in_load) commit_words();
    sess_q.delete();
    exp_prog_len = 0;
    exp_sum      = 8'h00;
    in_load      = 1'b0;
    exp_run      = 1'b0;
    direinstru   = 32'd0;
    #1;
    check("rst_state", 32'(dbg_state), 32'd0);
    check("rst_run", 32'(run), 32'd0);
    check("rst_ready", 32'(load_ready), 32'd0);
    check("rst_done", 32'(load_done), 32'd0);
    check("rst_prog_len", 32'(prog_len), 32'd0);
    check("rst_instru", instru, 32'd0);
`ifdef MEM_INSTRU_CHECKSUM_EN
    check("rst_sum", 32'(load_sum), 32'd0);
`endif
    reset = 1'b0;
    tick();
    exp_run = 1'b1;
    check("idle_to_run", 32'(run), 32'd1);
    check("idle_no_done", 32'(load_done), 32'd0);
    check("idle_prog_len", 32'(prog_len), 32'(exp_prog_len));
    check("idle_state", 32'(dbg_state), 32'd2);
  endtask

  task automatic start_load();
    load_en    = 1'b1;
    direinstru = 32'($urandom_range(0, DEPTH - 1));
    #1;
    check("run_drop", 32'(run), 32'd0);
    check("instru_drop", instru, 32'd0);
    tick();
    sess_q.delete();
    in_load = 1'b1;
    exp_run = 1'b0;
    check("load_entry_ready", 32'(load_ready), 32'd1);
    check("load_state", 32'(dbg_state), 32'd1);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit drop);
    bit exp_rdy;
    load_byte  = b;
    load_valid = 1'b1;
    if (drop) load_en = 1'b0;
    direinstru = $urandom;
    #1;
    exp_rdy = in_load && (sess_q.size() < 4 * DEPTH);
    check("load_ready", 32'(load_ready), 32'(exp_rdy));
    check("run_level", 32'(run), 32'(exp_run));
    if (!exp_run) check("instru_nop", instru, 32'd0);
    if (exp_rdy) sess_q.push_back(b);
    tick();
    load_valid = 1'b0;
    if (in_load && (drop || sess_q.size() == 4 * DEPTH)) close_checks();
    else check("no_spurious_done", 32'(load_done), 32'd0);
  endtask

  task automatic idle_cycle();
    load_valid = 1'b0;
    #1;
    check("gap_ready", 32'(load_ready), 32'(in_load));
    tick();
    check("gap_no_done", 32'(load_done), 32'd0);
  endtask

  task automatic end_load();
    load_en    = 1'b0;
    load_valid = 1'b0;
    tick();
    if (in_load) close_checks();
    tick();
    check("done_one_cycle", 32'(load_done), 32'd0);
  endtask

  task automatic verify_mem();
    logic [31:0] a;
    for (int i = 0; i < DEPTH; i++) begin
      if (known[i]) begin
        direinstru = 32'(i);
        #1;
        check("instru_read", instru, model_mem[i]);
        tick();
      end
    end
    for (int k = 0; k < 8; k++) begin
      a = $urandom;
      if (a < 32'(DEPTH)) a = a | 32'h0000_0100;
      direinstru = a;
      #1;
      check("instru_oor", instru, 32'd0);
      tick();
    end
  endtask

  // Stimulus
  initial begin
    logic [7:0] prog8 [8];
    logic [7:0] prog4 [4];
    int         len;
    bit         drop;

    prog8 = '{8'h12, 8'h34, 8'h56, 8'h78, 8'hAB, 8'hCD, 8'hEF, 8'h01};
    prog4 = '{8'h00, 8'h00, 8'h00, 8'h2A};
    for (int i = 0; i < DEPTH; i++) begin
      known[i]     = 1'b0;
      model_mem[i] = 32'd0;
    end
    reset      = 1'b1;
    load_en    = 1'b0;
    load_valid = 1'b0;
    load_byte  = 8'h00;
    direinstru = 32'd0;
    in_load    = 1'b0;
    tick();
    do_reset();
    direinstru = 32'd300;
    #1;
    check("instru_300", instru, 32'd0);
    tick();

    // Two complete words, then an immediate read of word 1.
    start_load();
    foreach (prog8[i]) send_byte(prog8[i], 1'b0);
    end_load();
    direinstru = 32'd1;
    #1;
    check("instru_word1", instru, 32'hABCD_EF01);
    tick();
    verify_mem();

    // Five bytes: the trailing partial word is discarded.
    start_load();
    for (int i = 0; i < 5; i++) send_byte(8'($urandom), 1'b0);
    end_load();
    check("prog_len_5b", 32'(prog_len), 32'd1);
    verify_mem();

    // Overfill: 1028 bytes with load_en held, loader closes at 1024.
    start_load();
    for (int i = 0; i < 4 * DEPTH + 4; i++) send_byte(8'($urandom), 1'b0);
    check("prog_len_full", 32'(prog_len), 32'(DEPTH));
    load_en = 1'b0;
    tick();
    verify_mem();

    // Reset after the sixth byte aborts without load_done.
    start_load();
    for (int i = 0; i < 6; i++) send_byte(8'($urandom), 1'b0);
    do_reset();
    verify_mem();

    // Reload from RUN.
    start_load();
    foreach (prog4[i]) send_byte(prog4[i], 1'b0);
    end_load();
    direinstru = 32'd0;
    #1;
    check("instru_2a", instru, 32'h0000_002A);
    tick();
    verify_mem();

    // Random sessions with valid gaps; some drop load_en alongside the last byte.
    for (int s = 0; s < 6; s++) begin
      len  = $urandom_range(0, 30);
      drop = ($urandom_range(0, 1) == 1) && (len > 0);
      if (s == 0) begin
        len  = 12;
        drop = 1'b1;
      end
      start_load();
      for (int j = 0; j < len; j++) begin
        if ($urandom_range(0, 3) == 0) idle_cycle();
        send_byte(8'($urandom), drop && (j == len - 1));
      end
      if (drop) begin
        tick();
        check("drop_done_one_cycle", 32'(load_done), 32'd0);
      end else begin
        end_load();
      end
      verify_mem();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/mem_instru.md
Name: mem_instru

Overview:
- Instruction memory for the single-cycle processor; the responder to the PC's instruction-address output.
- Holds up to DEPTH 32-bit words.
- A byte-serial loader fills it after reset; in RUN state the memory returns the instruction at word address direinstru combinationally, within the same cycle.
- Outputs NOP (0) while not in RUN, so the core idles during program load.

Parameters:
- DEPTH, 256, number of 32-bit instruction words; matches PC wrap at 255.
- ADDR_W, 8, index width; DEPTH = 2**ADDR_W.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- direinstru  input  32  word address from the PC.
- instru  output  32  instruction word to the decoder.
- load_en  input  1  request and hold a program-load session.
- load_byte  input  8  program byte, MSB-first per word.
- load_valid  input  1  load_byte is valid this cycle.
- load_ready  output  1  loader accepts a byte this cycle.
- load_done  output  1  one-cycle pulse when a load session closes.
- run  output  1  high in RUN state; core may execute.
- prog_len  output  ADDR_W+1  number of complete words written in the last session.

Behaviour:
- Reset: state=IDLE, wptr=0, byte_cnt=0, shift reg=0, prog_len=0, load_ready=0, load_done=0, run=0. Memory contents are not cleared. Reset mid-load aborts the session without a load_done pulse.
- States: IDLE, LOAD, RUN.
- IDLE:
  - load_en=1 -> LOAD; clear wptr and byte_cnt.
  - load_en=0 -> RUN; existing contents are used.
- LOAD:
  - load_ready=1.
  - Byte accepted on load_valid & load_ready.
  - Accepted byte: shift = {shift[23:0], load_byte}; byte_cnt++.
  - On the 4th byte of a word: mem[wptr] <= {shift[23:0], load_byte}; wptr++; byte_cnt=0.
  - Data is big-endian: the first byte lands in bits [31:24].
- LOAD exit, whichever comes first:
  - load_en falls: any partial word (byte_cnt!=0) is discarded and never written.
  - wptr reaches DEPTH on a write: remaining bytes are not accepted; load_ready drops the next cycle.
- On exit: prog_len <= wptr (DEPTH when full), load_done pulses 1 cycle, state -> RUN.
- Simultaneous events: load_en falls in the same cycle as a 4th byte -> that word is written and counted, then exit.
- RUN:
  - run=1, load_ready=0.
  - instru = mem[direinstru[ADDR_W-1:0]] when direinstru < DEPTH; otherwise 0.
  - Read is asynchronous: zero-cycle latency from direinstru.
  - A load_en rising edge (0 in the previous cycle, 1 now) -> LOAD; run drops the same cycle.
- Outside RUN: instru=0 regardless of direinstru.
- Words beyond prog_len keep their prior contents.
- Arithmetic: wptr is ADDR_W+1 bits to represent DEPTH; no wrap-around on write.

Optional Feature:
- Macro: MEM_INSTRU_CHECKSUM_EN.
- Defined:
  - Adds output load_sum [7:0].
  - Modulo-256 sum of every accepted byte in the current/last session, including discarded partial-word bytes.
  - Cleared on reset and on LOAD entry; held stable in RUN.
- Undefined: port absent; no adder logic.

Test Plan:
- Reset then load_en=0 -> RUN after 1 cycle, run=1, prog_len=0, instru=0 for direinstru=300.
- Load bytes 12 34 56 78 AB CD EF 01, drop load_en -> load_done pulse, prog_len=2, mem[0]=0x12345678, mem[1]=0xABCDEF01; direinstru=1 gives 0xABCDEF01 the same cycle.
- Load 5 bytes then drop load_en -> prog_len=1, 5th byte discarded, mem[1] unchanged. With MEM_INSTRU_CHECKSUM_EN, load_sum equals the sum of all 5 bytes.
- Stream 1028 bytes with load_en held high -> load_ready low after the 1024th byte, prog_len=256, load_done pulse, run=1; mem[255] holds bytes 1021..1024.
- Assert reset after the 6th byte -> state IDLE, load_done never pulses, prog_len=0.
- From RUN, pulse load_en, load 4 bytes 00 00 00 2A -> run low during load; afterwards mem[0]=0x0000002A, prog_len=1, instru=0x0000002A for direinstru=0.
